// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the RV32 hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [4:0] REG_X0   = 5'd0;
  localparam int         NUM_OPS  = 2;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } shadow_t;

  // Memory stage wins over writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input shadow_t   mem,
                                         input shadow_t   wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem.we && mem.rd != REG_X0 && mem.rd == rs)
      sel = FWD_MEM;
    else if (wb.we && wb.rd != REG_X0 && wb.rd == rs)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;
  assign count  = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (inc && !w_full)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: operand forwarding,
// load-use stall, branch flush, and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  shadow_t r_mem, r_wb;

  // Bubbles arrive as RdE=0/RegWriteE=0, so the shadow never needs a stall/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_mem <= '{rd: RdE, we: RegWriteE};
      r_wb  <= r_mem;
    end
  end

  logic [NUM_OPS-1:0][4:0] w_rs_e;
  logic [NUM_OPS-1:0][1:0] w_fwd;

  assign w_rs_e = {Rs2E, Rs1E};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    assign w_fwd[g] = fwd_sel(w_rs_e[g], r_mem, r_wb);
  end

  assign ForwardAE = w_fwd[0];
  assign ForwardBE = w_fwd[1];

  logic w_lw_stall;

  assign w_lw_stall = (ResultSrcE == RES_LOAD) && (RdE != REG_X0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // A simultaneous redirect is resolved by the PC mux upstream, not here.
  assign StallF = w_lw_stall;
  assign StallD = w_lw_stall;
  assign FlushD = PCSrcE;
  assign FlushE = w_lw_stall || PCSrcE;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (w_lw_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (PCSrcE),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32 pipeline.
- Drives the flush input of the decode→execute stage register, plus stall/flush of fetch/decode and the operand-forwarding selects for the execute stage.
- Keeps internal shadow copies of the destination-register/write-enable fields for the memory and writeback stages, so it needs only execute-stage fields as inputs.
- Carries saturating stall/flush event counters for performance debug.

Parameters:
CNT_W, 32, width of the stall and flush event counters (saturating)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
Rs1D  input  5  source reg 1 of instruction in decode
Rs2D  input  5  source reg 2 of instruction in decode
Rs1E  input  5  source reg 1 at execute-register output
Rs2E  input  5  source reg 2 at execute-register output
RdE  input  5  destination reg at execute-register output
RegWriteE  input  1  write-enable at execute-register output
ResultSrcE  input  2  result select at execute-register output; 2'b01 = load
PCSrcE  input  1  taken branch or jump resolved in execute
cnt_clr  input  1  synchronous clear of both counters
ForwardAE  output  2  operand A select: 00 regfile, 01 writeback result, 10 ALU result in memory
ForwardBE  output  2  operand B select, same encoding
StallF  output  1  hold PC register
StallD  output  1  hold fetch→decode register
FlushD  output  1  clear fetch→decode register
FlushE  output  1  clear decode→execute register (flush input of that stage)
stall_cnt  output  CNT_W  cycles with StallD asserted
flush_cnt  output  CNT_W  cycles with PCSrcE asserted

Behaviour:
- Shadow pipeline, updated every rising edge with no stall or enable:
  - RdM <= RdE, RegWriteM <= RegWriteE
  - RdW <= RdM, RegWriteW <= RegWriteM
- A flushed execute register presents RdE=0 and RegWriteE=0, so a bubble propagates naturally with no special handling.
- Reset asynchronously clears RdM, RegWriteM, RdW, RegWriteW, stall_cnt and flush_cnt to 0.
  - Effect at reset: ForwardAE = ForwardBE = 00.
  - Stall/flush outputs depend only on inputs: with all inputs 0 they read 0.
- Forwarding is combinational and evaluated per operand. Shown for A; B is identical using Rs2E:
  - 10 if RegWriteM && RdM != 0 && RdM == Rs1E
  - else 01 if RegWriteW && RdW != 0 && RdW == Rs1E
  - else 00
  - Memory stage has priority over writeback when both match.
  - x0 is never forwarded.
- Load-use detection, combinational:
  - lwStall = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)
- Control outputs, combinational:
  - StallF = StallD = lwStall
  - FlushD = PCSrcE
  - FlushE = lwStall || PCSrcE
- Simultaneous lwStall and PCSrcE: all four of StallF, StallD, FlushD, FlushE assert.
  - The redirect wins: the PC register loads the target regardless of StallF, because PCSrcE muxes the PC input.
  - This rule is fixed for the top level; this block does not arbitrate it.
- Latency:
  - Forwarding reflects a producer one cycle (M) or two cycles (W) after it leaves execute.
  - A load-use stall lasts exactly one cycle: the next cycle the load is in M, RdE = 0, and the hazard is resolved by forwarding from W on the following cycle.
- Counters, updated on the rising edge:
  - cnt_clr has priority: both counters <= 0.
  - Otherwise stall_cnt += 1 if StallD, and flush_cnt += 1 if PCSrcE.
  - Each counter saturates at all-ones and holds; it never wraps.
  - Both counters may increment in the same cycle.
- Reset mid-operation:
  - Shadow state clears immediately, with no forwarding from pre-reset instructions.
  - Counters return to 0 and resume counting after reset is released.

Decomposition:
- Shared pipeline package holds:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - RES_LOAD = 2'b01, the ResultSrc load encoding
  - REG_X0 = 5'd0
- One natural sub-module, sat_counter (parameter W, inputs clk, reset, clr, inc), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset held, then released with all inputs 0 → ForwardAE = ForwardBE = 00, all stall/flush outputs 0, stall_cnt = flush_cnt = 0.
- Cycle n: RdE = 5, RegWriteE = 1. Cycle n+1: Rs1E = 5 → ForwardAE = 10. Hold Rs1E = 5 into cycle n+2 with RegWriteE = 0 → ForwardAE = 01. Cycle n+3 → ForwardAE = 00.
- Same-register priority and x0: cycle n RdE = 7, cycle n+1 RdE = 7, both with RegWriteE = 1; cycle n+2 Rs2E = 7 → ForwardBE = 10. Repeat with RdE = 0 → ForwardBE = 00.
- ResultSrcE = 01, RdE = 3, Rs2D = 3 → StallF = StallD = FlushE = 1, FlushD = 0; stall_cnt increments by 1. Repeat with RdE = 0 → no stall.
- PCSrcE = 1 together with the load-use condition above → FlushD = FlushE = StallF = StallD = 1; flush_cnt and stall_cnt each +1 on the same edge.
- Force StallD for 2^CNT_W + 3 cycles (CNT_W = 4 build) → stall_cnt saturates at 15 and holds. Pulse cnt_clr → 0 next edge. Assert reset mid-run → all shadow state and counters 0 asynchronously.
